// File: rtl/spi_mem_pkg.sv
// Shared constants, FSM state type and frame builder for the cpu-bus to serial-SRAM bridge.
// One frame is opcode, 16-bit address and one data byte, sent MSB first.
package spi_mem_pkg;

  localparam int FRAME_BITS = 32;

  localparam logic [7:0] SPI_OP_READ  = 8'h03;
  localparam logic [7:0] SPI_OP_WRITE = 8'h02;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_e;

  // Reads send a zero data byte; the memory drives MISO during that field instead.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic        is_read,
                                                        input logic [15:0] addr,
                                                        input logic [7:0]  wdata);
    return is_read ? {SPI_OP_READ, addr, 8'h00} : {SPI_OP_WRITE, addr, wdata};
  endfunction

endpackage

// File: rtl/spi_mem_bridge_if.sv
// CPU bus port between the core and the serial-SRAM bridge.
// The cpu holds bus_read/bus_write until it sees bus_wait low for one cycle.
interface spi_mem_bridge_if;

  logic [15:0] bus_address_in;
  logic [7:0]  bus_data_in;
  logic        bus_read;
  logic        bus_write;
  logic [7:0]  bus_data_out;
  logic        bus_wait;

  modport master (
    output bus_address_in, bus_data_in, bus_read, bus_write,
    input  bus_data_out, bus_wait
  );

  modport slave (
    input  bus_address_in, bus_data_in, bus_read, bus_write,
    output bus_data_out, bus_wait
  );

endinterface

// File: rtl/spi_mem_shifter.sv
// SPI mode-0 bit engine: start loads the frame, one idle cycle follows, then 32 bits of 2*SCK_DIV cycles each.
// done pulses in the last high-SCK cycle; MISO is sampled on the rising-SCK edge of bits 24..31.
module spi_mem_shifter
  import spi_mem_pkg::*;
#(
  parameter int unsigned SCK_DIV = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  busy,
  output logic                  done,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso,
  output logic [7:0]            rx_data
);

  localparam int unsigned        DIV_W    = 8;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SCK_DIV - 1);
  localparam logic [5:0]         BIT_LAST = 6'(FRAME_BITS - 1);
  localparam logic [5:0]         RX_FIRST = 6'd24;

  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [7:0]            rx_q, rx_d;
  logic [5:0]            bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic                  sck_q, sck_d;
  logic                  busy_q, busy_d;
  logic                  arm_q, arm_d;
  logic                  phase_end;

  always_comb begin
    tx_d      = tx_q;
    rx_d      = rx_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    sck_d     = sck_q;
    busy_d    = busy_q;
    arm_d     = 1'b0;
    done      = 1'b0;
    phase_end = (div_cnt_q == DIV_LAST);

    if (start) begin
      tx_d      = frame;
      bit_cnt_d = '0;
      div_cnt_d = '0;
      sck_d     = 1'b0;
      busy_d    = 1'b1;
      arm_d     = 1'b1;
    end else if (busy_q && !arm_q) begin
      if (!phase_end) begin
        div_cnt_d = div_cnt_q + 1'b1;
      end else begin
        div_cnt_d = '0;
        if (!sck_q) begin
          sck_d = 1'b1;
          if (bit_cnt_q >= RX_FIRST) rx_d = {rx_q[6:0], miso};
        end else begin
          // Falling SCK: advance MOSI so it only ever moves while SCK is low.
          sck_d = 1'b0;
          if (bit_cnt_q == BIT_LAST) begin
            busy_d = 1'b0;
            done   = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            tx_d      = {tx_q[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q      <= '0;
      rx_q      <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      sck_q     <= 1'b0;
      busy_q    <= 1'b0;
      arm_q     <= 1'b0;
    end else begin
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      sck_q     <= sck_d;
      busy_q    <= busy_d;
      arm_q     <= arm_d;
    end
  end

  assign busy    = busy_q;
  assign sck     = sck_q;
  assign mosi    = busy_q & tx_q[FRAME_BITS-1];
  assign rx_data = rx_q;

endmodule

// File: rtl/spi_mem_bridge.sv
// CPU bus to 23LC512-class serial SRAM bridge; DONE arrives 3+64*SCK_DIV cycles after accept, bus_wait low only then.
// Optional SPI_MEM_WP_EN: writes below WP_LIMIT complete immediately without touching the memory.
module spi_mem_bridge
  import spi_mem_pkg::*;
#(
  parameter int unsigned SCK_DIV = 1
`ifdef SPI_MEM_WP_EN
  , parameter logic [15:0] WP_LIMIT = 16'h8000
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  spi_mem_bridge_if.slave        bus,
  output logic                   spi_cs_n,
  output logic                   spi_sck,
  output logic                   spi_mosi,
  input  logic                   spi_miso
);

  state_e     state_q, state_d;
  logic       rd_op_q, rd_op_d;
  logic [7:0] data_out_q, data_out_d;
  logic       cs_n_q, cs_n_d;
  logic       wait_q, wait_d;

  logic       req;
  logic       wp_hit;
  logic       sh_start;
  logic       sh_busy;
  logic       sh_done;
  logic [7:0] sh_rx;

  assign req = bus.bus_read | bus.bus_write;

`ifdef SPI_MEM_WP_EN
  assign wp_hit = bus.bus_write && !bus.bus_read && (bus.bus_address_in < WP_LIMIT);
`else
  assign wp_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rd_op_d    = rd_op_q;
    data_out_d = data_out_q;
    sh_start   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          rd_op_d = bus.bus_read;
          if (wp_hit) begin
            state_d = DONE;
          end else begin
            sh_start = 1'b1;
            state_d  = SETUP;
          end
        end
      end
      SETUP:   state_d = sh_busy ? SHIFT : IDLE;
      SHIFT:   if (sh_done) state_d = HOLD;
      HOLD: begin
        state_d = DONE;
        if (rd_op_q) data_out_d = sh_rx;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    cs_n_d = !(state_d inside {SETUP, SHIFT, HOLD});
    wait_d = (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_op_q    <= 1'b0;
      data_out_q <= 8'h00;
      cs_n_q     <= 1'b1;
      wait_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      rd_op_q    <= rd_op_d;
      data_out_q <= data_out_d;
      cs_n_q     <= cs_n_d;
      wait_q     <= wait_d;
    end
  end

  spi_mem_shifter #(
    .SCK_DIV (SCK_DIV)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .start   (sh_start),
    .frame   (build_frame(bus.bus_read, bus.bus_address_in, bus.bus_data_in)),
    .busy    (sh_busy),
    .done    (sh_done),
    .sck     (spi_sck),
    .mosi    (spi_mosi),
    .miso    (spi_miso),
    .rx_data (sh_rx)
  );

  assign spi_cs_n         = cs_n_q;
  assign bus.bus_wait     = wait_q;
  assign bus.bus_data_out = data_out_q;

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Directed bench: two bridges (SCK_DIV=1 and 3), each with a behavioural 23LC512 byte-mode model.
module tb_spi_mem_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  spi_mem_bridge_if bif1 ();
  spi_mem_bridge_if bif3 ();

  logic cs1, sck1, mosi1;
  logic miso1 = 1'b0;
  logic cs3, sck3, mosi3;
  logic miso3 = 1'b0;

  spi_mem_bridge #(.SCK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bif1),
    .spi_cs_n(cs1), .spi_sck(sck1), .spi_mosi(mosi1), .spi_miso(miso1)
  );

  spi_mem_bridge #(.SCK_DIV(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bif3),
    .spi_cs_n(cs3), .spi_sck(sck3), .spi_mosi(mosi3), .spi_miso(miso3)
  );

  // Serial SRAM models: shift MOSI on rising SCK, drive read data on falling SCK.
  logic [7:0]  mem1 [0:65535];
  logic [31:0] sh1 = '0, frame1 = '0;
  logic [15:0] addr1 = '0;
  int          bits1 = 0;

  always @(posedge sck1 or posedge cs1) begin
    if (cs1) begin
      if (bits1 == 32) frame1 = sh1;
      bits1 = 0;
    end else begin
      sh1 = {sh1[30:0], mosi1};
      bits1++;
      if (bits1 == 24) addr1 = sh1[15:0];
      if (bits1 == 32 && sh1[31:24] == 8'h02) mem1[sh1[23:8]] = sh1[7:0];
    end
  end

  always @(negedge sck1)
    if (!cs1 && bits1 >= 24 && bits1 < 32) miso1 = mem1[addr1][3'(31 - bits1)];

  logic [7:0]  mem3 [0:65535];
  logic [31:0] sh3 = '0, frame3 = '0;
  logic [15:0] addr3 = '0;
  int          bits3 = 0;

  always @(posedge sck3 or posedge cs3) begin
    if (cs3) begin
      if (bits3 == 32) frame3 = sh3;
      bits3 = 0;
    end else begin
      sh3 = {sh3[30:0], mosi3};
      bits3++;
      if (bits3 == 24) addr3 = sh3[15:0];
      if (bits3 == 32 && sh3[31:24] == 8'h02) mem3[sh3[23:8]] = sh3[7:0];
    end
  end

  always @(negedge sck3)
    if (!cs3 && bits3 >= 24 && bits3 < 32) miso3 = mem3[addr3][3'(31 - bits3)];

  // One cpu transaction on dut1, starting and ending on a falling clk edge.
  task automatic txn1(input logic rd, input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                      output int lat, output logic wait_after, output logic cs_seen,
                      output logic [7:0] dout_done);
    bif1.bus_read       = rd;
    bif1.bus_write      = wr;
    bif1.bus_address_in = addr;
    bif1.bus_data_in    = wd;
    lat       = -1;
    cs_seen   = 1'b0;
    dout_done = 8'hxx;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (!cs1) cs_seen = 1'b1;
      if (!bif1.bus_wait) begin
        lat       = n;
        dout_done = bif1.bus_data_out;
        break;
      end
    end
    bif1.bus_read  = 1'b0;
    bif1.bus_write = 1'b0;
    @(negedge clk);
    wait_after = bif1.bus_wait;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (cs1 !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", cs1); end
    checks++; if (sck1 !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b want 0", sck1); end
    checks++; if (mosi1 !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", mosi1); end
    checks++; if (bif1.bus_wait !== 1'b1) begin errors++; $display("FAIL reset_wait: got %b want 1", bif1.bus_wait); end
    checks++; if (bif1.bus_data_out !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", bif1.bus_data_out); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bif1.bus_wait !== 1'b1) begin errors++; $display("FAIL idle_wait: got %b want 1", bif1.bus_wait); end
    checks++; if (cs3 !== 1'b1) begin errors++; $display("FAIL idle_cs_n_div3: got %b want 1", cs3); end
  endtask

  task automatic test_read();
    int lat; logic wa, cs_seen; logic [7:0] dd;
    mem1[16'h1234] = 8'hA5;
    txn1(1'b1, 1'b0, 16'h1234, 8'h00, lat, wa, cs_seen, dd);
    checks++; if (lat !== 67) begin errors++; $display("FAIL read_latency: got %0d want 67", lat); end
    checks++; if (wa !== 1'b1) begin errors++; $display("FAIL read_wait_one_cycle: got %b want 1", wa); end
    checks++; if (frame1 !== 32'h03123400) begin errors++; $display("FAIL read_frame: got %h want 03123400", frame1); end
    checks++; if (dd !== 8'hA5) begin errors++; $display("FAIL read_data: got %h want a5", dd); end
    checks++; if (bif1.bus_data_out !== 8'hA5) begin errors++; $display("FAIL read_data_held: got %h want a5", bif1.bus_data_out); end
  endtask

  task automatic test_write();
    int lat; logic wa, cs_seen; logic [7:0] dd;
    txn1(1'b0, 1'b1, 16'hFF00, 8'h3C, lat, wa, cs_seen, dd);
    checks++; if (lat !== 67) begin errors++; $display("FAIL write_latency: got %0d want 67", lat); end
    checks++; if (frame1 !== 32'h02FF003C) begin errors++; $display("FAIL write_frame: got %h want 02ff003c", frame1); end
    checks++; if (mem1[16'hFF00] !== 8'h3C) begin errors++; $display("FAIL write_mem: got %h want 3c", mem1[16'hFF00]); end
    checks++; if (dd !== 8'hA5) begin errors++; $display("FAIL write_dout_kept: got %h want a5", dd); end
  endtask

  task automatic test_read_write_both();
    int lat; logic wa, cs_seen; logic [7:0] dd;
    mem1[16'h0010] = 8'h5A;
    txn1(1'b1, 1'b1, 16'h0010, 8'hEE, lat, wa, cs_seen, dd);
    checks++; if (lat !== 67) begin errors++; $display("FAIL both_latency: got %0d want 67", lat); end
    checks++; if (frame1 !== 32'h03001000) begin errors++; $display("FAIL both_frame: got %h want 03001000", frame1); end
    checks++; if (dd !== 8'h5A) begin errors++; $display("FAIL both_data: got %h want 5a", dd); end
    checks++; if (mem1[16'h0010] !== 8'h5A) begin errors++; $display("FAIL both_no_write: got %h want 5a", mem1[16'h0010]); end
  endtask

`ifdef SPI_MEM_WP_EN
  task automatic test_write_protect();
    int lat; logic wa, cs_seen; logic [7:0] dd;
    mem1[16'h0100] = 8'h99;
    txn1(1'b0, 1'b1, 16'h0100, 8'h11, lat, wa, cs_seen, dd);
    checks++; if (lat !== 1) begin errors++; $display("FAIL wp_latency: got %0d want 1", lat); end
    checks++; if (cs_seen !== 1'b0) begin errors++; $display("FAIL wp_cs_activity: got %b want 0", cs_seen); end
    checks++; if (mem1[16'h0100] !== 8'h99) begin errors++; $display("FAIL wp_mem: got %h want 99", mem1[16'h0100]); end
    checks++; if (dd !== 8'h5A) begin errors++; $display("FAIL wp_dout_kept: got %h want 5a", dd); end
    txn1(1'b0, 1'b1, 16'h8000, 8'h22, lat, wa, cs_seen, dd);
    checks++; if (lat !== 67) begin errors++; $display("FAIL wp_limit_latency: got %0d want 67", lat); end
    checks++; if (frame1 !== 32'h02800022) begin errors++; $display("FAIL wp_limit_frame: got %h want 02800022", frame1); end
    checks++; if (mem1[16'h8000] !== 8'h22) begin errors++; $display("FAIL wp_limit_mem: got %h want 22", mem1[16'h8000]); end
  endtask
`endif

  task automatic test_reset_mid_transfer();
    logic bad;
    bif1.bus_address_in = 16'hFFFF;
    bif1.bus_read       = 1'b1;
    // Cycle 20 after accept is SHIFT bit 9, an address bit that is 1.
    repeat (20) @(negedge clk);
    checks++; if (cs1 !== 1'b0) begin errors++; $display("FAIL mid_cs_active: got %b want 0", cs1); end
    checks++; if (mosi1 !== 1'b1) begin errors++; $display("FAIL mid_mosi_bit9: got %b want 1", mosi1); end
    rst           = 1'b1;
    bif1.bus_read = 1'b0;
    @(negedge clk);
    checks++; if (cs1 !== 1'b1) begin errors++; $display("FAIL mid_rst_cs_n: got %b want 1", cs1); end
    checks++; if (sck1 !== 1'b0) begin errors++; $display("FAIL mid_rst_sck: got %b want 0", sck1); end
    checks++; if (mosi1 !== 1'b0) begin errors++; $display("FAIL mid_rst_mosi: got %b want 0", mosi1); end
    checks++; if (bif1.bus_wait !== 1'b1) begin errors++; $display("FAIL mid_rst_wait: got %b want 1", bif1.bus_wait); end
    checks++; if (bif1.bus_data_out !== 8'h00) begin errors++; $display("FAIL mid_rst_dout: got %h want 00", bif1.bus_data_out); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!bif1.bus_wait || !cs1) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL mid_no_done: got %b want 0", bad); end
  endtask

  task automatic test_back_to_back();
    int d1, d2, cs_hi;
    logic counting, wa;
    logic [7:0]  rd_dout;
    logic [31:0] f_rd;
    d1 = -1; d2 = -1; cs_hi = 0; counting = 1'b0; rd_dout = 8'hxx; f_rd = 'x;
    mem3[16'h4321]      = 8'hC3;
    bif3.bus_address_in = 16'h4321;
    bif3.bus_data_in    = 8'h00;
    bif3.bus_write      = 1'b0;
    bif3.bus_read       = 1'b1;
    for (int n = 1; n <= 600; n++) begin
      @(negedge clk);
      if (!bif3.bus_wait && d1 < 0) begin
        d1       = n;
        rd_dout  = bif3.bus_data_out;
        f_rd     = frame3;
        counting = 1'b1;
        bif3.bus_read       = 1'b0;
        bif3.bus_write      = 1'b1;
        bif3.bus_address_in = 16'h9000;
        bif3.bus_data_in    = 8'h77;
      end else if (!bif3.bus_wait) begin
        d2 = n;
        bif3.bus_write = 1'b0;
      end
      if (counting) begin
        if (cs3) cs_hi++;
        else counting = 1'b0;
      end
      if (d2 >= 0) break;
    end
    @(negedge clk);
    wa = bif3.bus_wait;
    checks++; if (d1 !== 195) begin errors++; $display("FAIL b2b_read_latency: got %0d want 195", d1); end
    checks++; if (d2 - d1 !== 196) begin errors++; $display("FAIL b2b_write_latency: got %0d want 196", d2 - d1); end
    checks++; if (cs_hi !== 2) begin errors++; $display("FAIL b2b_cs_high: got %0d want 2", cs_hi); end
    checks++; if (f_rd !== 32'h03432100) begin errors++; $display("FAIL b2b_read_frame: got %h want 03432100", f_rd); end
    checks++; if (rd_dout !== 8'hC3) begin errors++; $display("FAIL b2b_read_data: got %h want c3", rd_dout); end
    checks++; if (frame3 !== 32'h02900077) begin errors++; $display("FAIL b2b_write_frame: got %h want 02900077", frame3); end
    checks++; if (mem3[16'h9000] !== 8'h77) begin errors++; $display("FAIL b2b_write_mem: got %h want 77", mem3[16'h9000]); end
    checks++; if (bif3.bus_data_out !== 8'hC3) begin errors++; $display("FAIL b2b_dout_kept: got %h want c3", bif3.bus_data_out); end
    checks++; if (wa !== 1'b1) begin errors++; $display("FAIL b2b_wait_one_cycle: got %b want 1", wa); end
  endtask

  initial begin
    bif1.bus_read = 1'b0; bif1.bus_write = 1'b0; bif1.bus_address_in = '0; bif1.bus_data_in = '0;
    bif3.bus_read = 1'b0; bif3.bus_write = 1'b0; bif3.bus_address_in = '0; bif3.bus_data_in = '0;
    test_reset();
    test_read();
    test_write();
    test_read_write_both();
`ifdef SPI_MEM_WP_EN
    test_write_protect();
`endif
    test_reset_mid_transfer();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
